// File: rtl/wb_regfile_scoreboard.sv
// Writeback stage: result mux, 16x32 register file with same-cycle decode bypass,
// and a per-register pending-write scoreboard that raises the decode RAW stall.
module wb_regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int NREGS  = 16,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] WB_MemData,
   input  logic [DATA_W-1:0] WB_ALUResult,
   input  logic [ADDR_W-1:0] WB_rd,
   input  logic              WB_MemToReg,
   input  logic              WB_RegWrite,
   output logic [DATA_W-1:0] WB_Result,
   input  logic [ADDR_W-1:0] ID_rs1,
   input  logic [ADDR_W-1:0] ID_rs2,
   input  logic              ID_uses_rs1,
   input  logic              ID_uses_rs2,
   output logic [DATA_W-1:0] ID_rs1_data,
   output logic [DATA_W-1:0] ID_rs2_data,
   input  logic              ID_issue,
   input  logic [ADDR_W-1:0] ID_issue_rd,
   output logic              ID_stall,
   output logic              sb_overflow,
   output logic              sb_underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [CNT_W-1:0]  cnt_q  [NREGS];
   logic [CNT_W-1:0]  cnt_d  [NREGS];
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic [NREGS-1:0]  incHit, decHit;
   logic [CNT_W-1:0]  cntRs1, cntRs2;
   logic              haz1, haz2, issueAccept;

   assign WB_Result   = WB_MemToReg ? WB_MemData : WB_ALUResult;
   assign ID_rs1_data = (WB_RegWrite && WB_rd == ID_rs1) ? WB_Result : regs_q[ID_rs1];
   assign ID_rs2_data = (WB_RegWrite && WB_rd == ID_rs2) ? WB_Result : regs_q[ID_rs2];

   // A single pending write that is retiring this cycle is covered by the bypass.
   assign cntRs1 = cnt_q[ID_rs1];
   assign cntRs2 = cnt_q[ID_rs2];
   assign haz1   = ID_uses_rs1 && (cntRs1 != '0) &&
                   !(cntRs1 == CNT_ONE && WB_RegWrite && WB_rd == ID_rs1);
   assign haz2   = ID_uses_rs2 && (cntRs2 != '0) &&
                   !(cntRs2 == CNT_ONE && WB_RegWrite && WB_rd == ID_rs2);

   assign ID_stall     = haz1 | haz2;
   assign issueAccept  = ID_issue && !ID_stall;
   assign sb_overflow  = overflow_q;
   assign sb_underflow = underflow_q;

   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      incHit      = '0;
      decHit      = '0;
      for (int i = 0; i < NREGS; i++) begin
         cnt_d[i]  = cnt_q[i];
         incHit[i] = issueAccept && (ID_issue_rd == ADDR_W'(i));
         decHit[i] = WB_RegWrite && (WB_rd == ADDR_W'(i));
         if (incHit[i] && !decHit[i]) begin
            if (cnt_q[i] == CNT_MAX) overflow_d = 1'b1;
            else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (decHit[i] && !incHit[i]) begin
            if (cnt_q[i] == '0) underflow_d = 1'b1;
            else                cnt_d[i] = cnt_q[i] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         if (WB_RegWrite) regs_q[WB_rd] <= WB_Result;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: bypass, RAW stall, scoreboard saturation,
// simultaneous issue/retire, sticky error flags and asynchronous reset.
module tb_wb_regfile_scoreboard;

   logic        clk;
   logic        rst_n;
   logic [31:0] wbMemData, wbAluResult, wbResult;
   logic [3:0]  wbRd, idRs1, idRs2, idIssueRd;
   logic        wbMemToReg, wbRegWrite;
   logic        idUsesRs1, idUsesRs2, idIssue;
   logic [31:0] idRs1Data, idRs2Data;
   logic        idStall, sbOverflow, sbUnderflow;

   int checks   = 0;
   int failures = 0;

   wb_regfile_scoreboard dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .WB_MemData   (wbMemData),
      .WB_ALUResult (wbAluResult),
      .WB_rd        (wbRd),
      .WB_MemToReg  (wbMemToReg),
      .WB_RegWrite  (wbRegWrite),
      .WB_Result    (wbResult),
      .ID_rs1       (idRs1),
      .ID_rs2       (idRs2),
      .ID_uses_rs1  (idUsesRs1),
      .ID_uses_rs2  (idUsesRs2),
      .ID_rs1_data  (idRs1Data),
      .ID_rs2_data  (idRs2Data),
      .ID_issue     (idIssue),
      .ID_issue_rd  (idIssueRd),
      .ID_stall     (idStall),
      .sb_overflow  (sbOverflow),
      .sb_underflow (sbUnderflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after a rising edge and settle 2 units before checking.
   task automatic applyStimulus(input logic we, input logic [3:0] rd, input logic m2r,
                                input logic [31:0] mem, input logic [31:0] alu,
                                input logic [3:0] rs1, input logic u1,
                                input logic [3:0] rs2, input logic u2,
                                input logic iss, input logic [3:0] issRd);
      wbRegWrite  = we;
      wbRd        = rd;
      wbMemToReg  = m2r;
      wbMemData   = mem;
      wbAluResult = alu;
      idRs1       = rs1;
      idUsesRs1   = u1;
      idRs2       = rs2;
      idUsesRs2   = u2;
      idIssue     = iss;
      idIssueRd   = issRd;
      #2;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 5, 1, 15, 1, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] reset then reads");
      applyStimulus(0, 0, 0, 0, 0, 5, 1, 15, 1, 0, 0);
      checkOutput("rst_rs1_data", idRs1Data, 32'h0);
      checkOutput("rst_rs2_data", idRs2Data, 32'h0);
      checkOutput("rst_stall", {31'b0, idStall}, 32'h0);
      checkOutput("rst_overflow", {31'b0, sbOverflow}, 32'h0);
      checkOutput("rst_underflow", {31'b0, sbUnderflow}, 32'h0);

      $display("[TB] write and bypass");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
      nextCycle();
      applyStimulus(1, 3, 1, 32'hCAFEF00D, 32'h1, 3, 1, 0, 0, 0, 0);
      checkOutput("wb_result_mem", wbResult, 32'hCAFEF00D);
      checkOutput("bypass_rs1", idRs1Data, 32'hCAFEF00D);
      checkOutput("bypass_last_retire_stall", {31'b0, idStall}, 32'h0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      checkOutput("reg3_read", idRs1Data, 32'hCAFEF00D);
      checkOutput("reg3_stall", {31'b0, idStall}, 32'h0);
      checkOutput("reg3_underflow", {31'b0, sbUnderflow}, 32'h0);

      $display("[TB] RAW stall");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 7, 1, 7, 0, 0, 0);
      checkOutput("raw_stall_rs1", {31'b0, idStall}, 32'h1);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 7, 0, 7, 1, 0, 0);
      checkOutput("raw_stall_rs2", {31'b0, idStall}, 32'h1);
      applyStimulus(0, 0, 0, 0, 0, 7, 0, 7, 0, 0, 0);
      checkOutput("unused_no_stall", {31'b0, idStall}, 32'h0);
      applyStimulus(1, 7, 0, 32'hDEAD0000, 32'h42, 7, 1, 0, 0, 0, 0);
      checkOutput("wb_result_alu", wbResult, 32'h42);
      checkOutput("raw_retire_stall", {31'b0, idStall}, 32'h0);
      checkOutput("raw_retire_data", idRs1Data, 32'h42);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
      checkOutput("reg7_read", idRs1Data, 32'h42);
      checkOutput("reg7_stall", {31'b0, idStall}, 32'h0);

      $display("[TB] multiple in-flight and overflow");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 2);
      checkOutput("ovf_before", {31'b0, sbOverflow}, 32'h0);
      checkOutput("ovf_issue_no_stall", {31'b0, idStall}, 32'h0);
      nextCycle();
      applyStimulus(1, 2, 0, 0, 32'h100, 2, 1, 0, 0, 1, 10);
      checkOutput("ovf_after", {31'b0, sbOverflow}, 32'h1);
      checkOutput("retire1_stall", {31'b0, idStall}, 32'h1);
      nextCycle();
      applyStimulus(1, 2, 0, 0, 32'h200, 2, 1, 0, 0, 0, 0);
      checkOutput("retire2_stall", {31'b0, idStall}, 32'h1);
      nextCycle();
      applyStimulus(1, 2, 0, 0, 32'h300, 2, 1, 0, 0, 0, 0);
      checkOutput("retire3_stall", {31'b0, idStall}, 32'h0);
      checkOutput("retire3_data", idRs1Data, 32'h300);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 2, 1, 10, 1, 0, 0);
      checkOutput("drained_stall", {31'b0, idStall}, 32'h0);
      checkOutput("reg2_read", idRs1Data, 32'h300);

      $display("[TB] simultaneous inc/dec and underflow");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
      nextCycle();
      applyStimulus(1, 4, 0, 0, 32'h44, 0, 0, 0, 0, 1, 4);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
      checkOutput("incdec_stall", {31'b0, idStall}, 32'h1);
      checkOutput("incdec_reg4", idRs1Data, 32'h44);
      applyStimulus(1, 4, 0, 0, 32'h45, 4, 1, 0, 0, 0, 0);
      checkOutput("r4_retire_stall", {31'b0, idStall}, 32'h0);
      nextCycle();
      applyStimulus(1, 9, 0, 0, 32'h9, 0, 0, 0, 0, 0, 0);
      checkOutput("unf_before", {31'b0, sbUnderflow}, 32'h0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("unf_after", {31'b0, sbUnderflow}, 32'h1);
      checkOutput("ovf_sticky", {31'b0, sbOverflow}, 32'h1);

      $display("[TB] async reset mid-flight");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
         nextCycle();
      end
      applyStimulus(1, 6, 0, 0, 32'h55, 0, 0, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
      checkOutput("pre_rst_stall", {31'b0, idStall}, 32'h1);
      checkOutput("pre_rst_reg6", idRs1Data, 32'h55);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_stall", {31'b0, idStall}, 32'h0);
      checkOutput("async_rst_reg6", idRs1Data, 32'h0);
      checkOutput("async_rst_ovf", {31'b0, sbOverflow}, 32'h0);
      checkOutput("async_rst_unf", {31'b0, sbUnderflow}, 32'h0);
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 3, 1, 6, 1, 0, 0);
      checkOutput("post_rst_reg3", idRs1Data, 32'h0);
      checkOutput("post_rst_stall", {31'b0, idStall}, 32'h0);

      $display("[TB] issue with own source");
      applyStimulus(0, 0, 0, 0, 0, 5, 1, 0, 0, 1, 5);
      checkOutput("self_src_stall", {31'b0, idStall}, 32'h0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      checkOutput("self_src_pending", {31'b0, idStall}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_regfile_scoreboard.md
Name: wb_regfile_scoreboard

Overview:
Consumer end of the MEM/WB pipeline register. It selects the writeback value, MemData or ALUResult, and writes it into a 16 x 32-bit register file. It serves two decode-stage read ports with same-cycle write-to-read bypass. A per-register pending-write scoreboard generates the decode stall for RAW hazards against in-flight writes.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 4, register address width (matches rd width)
NREGS, 16, number of registers (2**ADDR_W)
CNT_W, 2, scoreboard counter width (max 3 in-flight writes per register: EX, MEM, WB)

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
WB_MemData  in  DATA_W  load data from MEM/WB
WB_ALUResult  in  DATA_W  ALU result from MEM/WB
WB_rd  in  ADDR_W  destination register
WB_MemToReg  in  1  1 = write MemData, 0 = write ALUResult
WB_RegWrite  in  1  writeback enable; also retires one scoreboard entry for WB_rd
WB_Result  out  DATA_W  selected writeback value (combinational, for EX forwarding)
ID_rs1, ID_rs2  in  ADDR_W  decode source addresses
ID_uses_rs1, ID_uses_rs2  in  1  source actually consumed by the instruction
ID_rs1_data, ID_rs2_data  out  DATA_W  read data (combinational, bypassed)
ID_issue  in  1  decode instruction advances and will write a register
ID_issue_rd  in  ADDR_W  its destination
ID_stall  out  1  RAW hazard, decode must hold
sb_overflow  out  1  sticky error flag: issue to a saturated counter
sb_underflow  out  1  sticky error flag: retire from a zero counter

Behaviour:
- Reset (async, rst_n=0): all registers = 0, all counters = 0, sb_overflow = sb_underflow = 0. Combinational outputs follow, so read data = 0 and ID_stall = 0. Reset mid-operation discards all pending entries immediately.
- WB_Result = WB_MemToReg ? WB_MemData : WB_ALUResult, always driven.
- Write: on posedge clk, if WB_RegWrite, reg[WB_rd] <= WB_Result. All 16 registers are writable; there is no hardwired zero.
- Read: ID_rsX_data = (WB_RegWrite && WB_rd == ID_rsX) ? WB_Result : reg[ID_rsX]. Latency is 0 cycles, and a same-cycle write is visible.
- Scoreboard: one CNT_W counter per register.
  - inc = ID_issue && !ID_stall, targeting ID_issue_rd.
  - dec = WB_RegWrite, targeting WB_rd.
  - inc and dec on the same register in the same cycle: counter unchanged.
  - inc with counter = 3: counter stays 3, sb_overflow <= 1.
  - dec with counter = 0: counter stays 0, sb_underflow <= 1.
  - Error flags clear only on reset.
- Hazard, per source X: hazX = ID_uses_rsX && cnt[ID_rsX] != 0 && !(cnt[ID_rsX] == 1 && WB_RegWrite && WB_rd == ID_rsX). The last retiring write is covered by the bypass.
- ID_stall = haz1 | haz2, combinational.
- ID_issue while ID_stall = 1 is ignored: no increment, no error.
- Issue whose destination equals its own source: the stall check uses the pre-increment count.
- Unused source addresses (uses = 0) never stall.

Test Plan:
1. Reset then reads: rst_n low 2 cycles, release. Read rs1 = 5, rs2 = 15 -> both data 0, ID_stall = 0, both flags 0.
2. Write and bypass: WB_RegWrite = 1, WB_rd = 3, MemToReg = 1, MemData = 0xCAFEF00D, ALUResult = 0x1. Same cycle rs1 = 3 -> 0xCAFEF00D. Next cycle with WB_RegWrite = 0 -> reg read 0xCAFEF00D.
3. RAW stall: issue rd = 7. Next cycle uses_rs1 = 1, rs1 = 7 -> stall = 1 for 2 cycles. In the cycle WB retires rd = 7 with ALUResult = 0x42 -> stall = 0, rs1_data = 0x42.
4. Multiple in-flight: issue rd = 2 on 3 consecutive cycles -> cnt = 3. A 4th issue while uses = 0 -> sb_overflow = 1, cnt stays 3. Stall persists until the 3rd retire cycle, then clears.
5. Simultaneous inc/dec: cnt[4] = 1, issue rd = 4 and retire rd = 4 same cycle -> cnt stays 1, next-cycle reader of r4 stalls. Retire to r9 with cnt 0 -> sb_underflow = 1.
6. Async reset mid-flight: cnt[6] = 2, reg[6] = 0x55. Assert rst_n between clock edges -> stall drops immediately, reg[6] reads 0, flags 0.
